// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Brief    : Shared push-button types and board timing constants.
// Revision : 1.0
// ============================================================================
package btn_pkg;

    localparam int CK_HZ       = 27_000_000;
    localparam int DEBOUNCE_MS = 10;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_WAIT_UP = 2'd3
    } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/sw_sync.sv
`default_nettype none
// ============================================================================
// Module   : sw_sync
// Brief    : Parameterised flop chain synchroniser for asynchronous inputs.
// Revision : 1.0
// ============================================================================
module sw_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Reset value is expected to be tied to a constant by the instantiating block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{i_rst_val}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Push-button synchroniser/debouncer with press, release and
//            long-press event pulses.
// Revision : 1.0
// ============================================================================
module button_debouncer
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = CK_HZ / 1000 * DEBOUNCE_MS,
    parameter int LONG_CYCLES     = CK_HZ,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic CK,
    input  logic RSTN,
    input  logic i_pin,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int              c_dw        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int              c_hw        = $clog2(LONG_CYCLES + 1);
    localparam logic [c_dw-1:0] c_db_last   = c_dw'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hw-1:0] c_long_last = c_hw'(LONG_CYCLES - 1);
    localparam logic [c_hw-1:0] c_long_max  = c_hw'(LONG_CYCLES);
    localparam logic            c_inv       = (ACTIVE_LOW != 0);

    logic            w_sync;
    logic            w_s;
    btn_state_t      r_state;
    btn_state_t      w_state_nxt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic [c_dw-1:0] r_dcnt;
    logic [c_hw-1:0] r_hcnt;
    logic            w_differs;
    logic            w_expire;
    logic            w_level_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_long_nxt;

    // Chain resets to the pin's idle level so the synced value starts released.
    sw_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (CK),
        .rst_n     (RSTN),
        .i_rst_val (c_inv),
        .i_d       (i_pin),
        .o_q       (w_sync)
    );

    assign w_s       = w_sync ^ c_inv;
    assign w_differs = (w_s != r_level);
    assign w_expire  = w_differs && (r_dcnt == c_db_last);

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_UP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_UP: begin
                if (w_expire) begin
                    w_state_nxt = ST_DOWN;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else if (w_s) begin
                    w_state_nxt = ST_WAIT_DN;
                end
            end
            ST_WAIT_DN: begin
                if (!w_s) begin
                    w_state_nxt = ST_UP;
                end else if (w_expire) begin
                    w_state_nxt = ST_DOWN;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end
            end
            ST_DOWN: begin
                if (w_expire) begin
                    w_state_nxt   = ST_UP;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else if (!w_s) begin
                    w_state_nxt = ST_WAIT_UP;
                end
            end
            ST_WAIT_UP: begin
                if (w_s) begin
                    w_state_nxt = ST_DOWN;
                end else if (w_expire) begin
                    w_state_nxt   = ST_UP;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_UP;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // A release accepted on the long-press cycle wins; the long pulse is dropped.
    assign w_long_nxt = r_level && (r_hcnt == c_long_last) && !w_release_nxt;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;

            if (!w_differs || w_expire) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end

            if (!r_level) begin
                r_hcnt <= '0;
            end else if (r_hcnt != c_long_max) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed self-checking bench for button_debouncer.
// Revision : 1.0
// ============================================================================
module tb_button_debouncer;

    logic CK   = 1'b0;
    logic RSTN = 1'b0;
    logic i_pin = 1'b0;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_long;
    wire [3:0] outs = {o_level, o_press, o_release, o_long};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pin;
        logic [3:0] exp;   // {level, press, release, long}
    } vec_t;

    vec_t vecs [50];

    button_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (0)
    ) dut (
        .CK        (CK),
        .RSTN      (RSTN),
        .i_pin     (i_pin),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Drive the pin right after an edge, then sample just after the next edge.
    task automatic cyc(input logic pin);
        i_pin = pin;
        @(posedge CK);
        #1;
    endtask

    initial begin
        int np, nr, nl, pe, re;
        logic early;

        // Clean 40-cycle hold then release; row j is checked at edge j+1.
        for (int j = 0; j < 50; j++) begin
            vecs[j].pin = (j < 40);
            vecs[j].exp = {(j >= 5 && j < 45), (j == 5), (j == 45), (j == 25)};
        end

        repeat (3) @(posedge CK);
        #1;
        check("reset_state", outs, 4'b0000);
        RSTN = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0);
        check("idle_after_reset", outs, 4'b0000);

        for (int j = 0; j < 50; j++) begin
            cyc(vecs[j].pin);
            check($sformatf("vec%0d", j), outs, vecs[j].exp);
        end

        // Bounce on press: 3 high, 1 low, then held high (final rise at edge 4).
        np = 0; nr = 0; pe = -1;
        for (int k = 0; k < 15; k++) begin
            cyc((k < 3) || (k >= 4));
            if (o_press)   begin np++; pe = k + 1; end
            if (o_release) nr++;
        end
        check("bounce_press_count", np, 1);
        check("bounce_press_edge", pe, 10);
        check("bounce_release_count", nr, 0);
        check("bounce_level", o_level, 1'b1);

        // Bounce on release: low 2, high 2, then held low (last fall at edge 4).
        np = 0; nr = 0; re = -1; early = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cyc((k == 2) || (k == 3));
            if (o_release) begin nr++; re = k + 1; end
            if (o_press) np++;
            if ((k + 1 < 10) && !o_level) early = 1'b1;
        end
        check("release_count", nr, 1);
        check("release_edge", re, 10);
        check("release_level_held", early, 1'b0);
        check("release_press_count", np, 0);

        // Release accepted exactly on the cycle the long pulse would fire.
        np = 0; nr = 0; nl = 0; pe = -1; re = -1;
        for (int k = 0; k < 35; k++) begin
            cyc(k < 20);
            if (o_press)   begin np++; pe = k + 1; end
            if (o_release) begin nr++; re = k + 1; end
            if (o_long)    nl++;
        end
        check("race_press_edge", pe, 6);
        check("race_release_edge", re, 26);
        check("race_long_count", nl, 0);
        check("race_release_count", nr, 1);

        // Asynchronous reset while the press pulse is high, button kept held.
        for (int k = 0; k < 6; k++) cyc(1'b1);
        check("rst_pre_press", o_press, 1'b1);
        #2 RSTN = 1'b0;
        #1;
        check("rst_async_clear", outs, 4'b0000);
        @(posedge CK);
        @(posedge CK);
        #1;
        check("rst_held", outs, 4'b0000);
        RSTN = 1'b1;
        np = 0; pe = -1;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1);
            if (o_press) begin np++; pe = k + 1; end
        end
        check("rst_repress_edge", pe, 6);
        check("rst_repress_count", np, 1);
        check("rst_repress_level", o_level, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
